gamepad_reader: RTL and testbench

Polls an SNES-style serial gamepad (latch / clock / data) and presents registered, active-high button states to the game core. It is the host end of the controller's shift-register protocol: it generates latch and clock, samples the serial data, and produces the direction, start and select signals that feed the game's `i_up`/`i_down`/`i_left`/`i_right`/`i_pause`/`i_restart` inputs. A poll is requested once per frame, normally from the VGA vsync edge.

---
 rtl/common.sv | 29 ++
 rtl/sync2.sv | 24 ++
 rtl/gamepad_reader.sv | 139 +++++++++++++
 tb/tb_gamepad_reader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared definitions for the gamepad reader: button bit order, button vector
// type and the poll state machine encoding.
package common;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;
    localparam int unsigned NUM_BTN    = 12;

    typedef logic [NUM_BTN-1:0] buttons_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } pad_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to 1 so an unknown line reads as unpressed.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gamepad_reader.sv
// Host side of an SNES-style latch/clock/data pad: one poll per i_start,
// 16 serial samples, registered active-high button state and press events.
module gamepad_reader
    import common::*;
#(
    parameter int unsigned LATCH_CYCLES = 300,
    parameter int unsigned CLK_HALF     = 75
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    output logic        o_pad_latch,
    output logic        o_pad_clk,
    input  logic        i_pad_data,
    output logic [11:0] o_buttons,
    output logic [11:0] o_pressed,
    output logic        o_valid,
    output logic        o_present,
    output logic        o_busy
);

    localparam int unsigned CNT_MAX = (LATCH_CYCLES > CLK_HALF) ? LATCH_CYCLES : CLK_HALF;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_HALF - 1);

    pad_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    idx_q;
    logic [15:0]   raw_q;
    logic [15:0]   raw_d;
    buttons_t      buttons_q;
    buttons_t      buttons_d;
    buttons_t      pressed_q;
    logic          latch_q;
    logic          pad_clk_q;
    logic          valid_q;
    logic          present_q;
    logic          busy_q;
    logic          data_sync;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (i_pad_data),
        .q_o   (data_sync)
    );

    // Fold the sample taken this cycle in, so the final bit feeds the DONE update.
    always_comb begin
        raw_d        = raw_q;
        raw_d[idx_q] = data_sync;
        buttons_d    = (raw_d[15:12] == 4'b1111) ? ~raw_d[11:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            raw_q     <= '0;
            buttons_q <= '0;
            pressed_q <= '0;
            latch_q   <= 1'b0;
            pad_clk_q <= 1'b1;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            pressed_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_LATCH;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_LATCH: begin
                    if (cnt_q == LATCH_LAST) begin
                        state_q <= ST_HIGH;
                        latch_q <= 1'b0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        raw_q <= raw_d;
                        if (idx_q == 4'd15) begin
                            state_q   <= ST_DONE;
                            present_q <= (raw_d[15:12] == 4'b1111);
                            buttons_q <= buttons_d;
                            pressed_q <= buttons_d & ~buttons_q;
                            valid_q   <= 1'b1;
                        end else begin
                            state_q   <= ST_LOW;
                            pad_clk_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt_q == HALF_LAST) begin
                        state_q   <= ST_HIGH;
                        pad_clk_q <= 1'b1;
                        idx_q     <= idx_q + 4'd1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pad_latch = latch_q;
    assign o_pad_clk   = pad_clk_q;
    assign o_buttons   = buttons_q;
    assign o_pressed   = pressed_q;
    assign o_valid     = valid_q;
    assign o_present   = present_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader with a shift-register pad model
// (load while latched, shift on pad-clk rise, LSB presented first).
module tb_gamepad_reader;
    import common::*;

    localparam int unsigned L         = 4;
    localparam int unsigned H         = 4;
    localparam int unsigned VALID_CYC = L + 31 * H + 1;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        i_start = 1'b0;
    logic        o_pad_latch;
    logic        o_pad_clk;
    logic        i_pad_data;
    logic [11:0] o_buttons;
    logic [11:0] o_pressed;
    logic        o_valid;
    logic        o_present;
    logic        o_busy;

    logic [15:0] pad_raw      = 16'h0000;
    logic [15:0] pad_sr       = 16'h0000;
    logic        pad_clk_prev = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gamepad_reader #(
        .LATCH_CYCLES (L),
        .CLK_HALF     (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .o_pad_latch (o_pad_latch),
        .o_pad_clk   (o_pad_clk),
        .i_pad_data  (i_pad_data),
        .o_buttons   (o_buttons),
        .o_pressed   (o_pressed),
        .o_valid     (o_valid),
        .o_present   (o_present),
        .o_busy      (o_busy)
    );

    always @(posedge clk) begin
        pad_clk_prev <= o_pad_clk;
        if (o_pad_latch)
            pad_sr <= pad_raw;
        else if (o_pad_clk && !pad_clk_prev)
            pad_sr <= {1'b1, pad_sr[15:1]};
    end

    assign i_pad_data = pad_sr[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_latch"},   32'(o_pad_latch), 32'd0);
        check({tag, "_padclk"},  32'(o_pad_clk),   32'd1);
        check({tag, "_buttons"}, 32'(o_buttons),   32'd0);
        check({tag, "_pressed"}, 32'(o_pressed),   32'd0);
        check({tag, "_valid"},   32'(o_valid),     32'd0);
        check({tag, "_present"}, 32'(o_present),   32'd0);
        check({tag, "_busy"},    32'(o_busy),      32'd0);
    endtask

    // i_start is high in cycle 0; cycles 1..140 are observed #1 after each edge.
    task automatic do_poll(input string tag, input logic [15:0] raw, input logic [11:0] exp_btn,
                           input logic [11:0] exp_prs, input logic exp_pres, input bit extra_starts);
        int   valid_cnt   = 0;
        int   valid_at    = -1;
        int   latch_rises = 0;
        int   latch_bad   = 0;
        int   lows        = 0;
        int   busy_bad    = 0;
        int   pressed_bad = 0;
        logic prev_latch  = 1'b0;
        logic prev_clk    = 1'b1;
        pad_raw = raw;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 140; c++) begin
            i_start = 1'b0;
            if (o_valid) begin
                valid_cnt++;
                valid_at = c;
                check({tag, "_buttons"}, 32'(o_buttons), 32'(exp_btn));
                check({tag, "_pressed"}, 32'(o_pressed), 32'(exp_prs));
                check({tag, "_present"}, 32'(o_present), 32'(exp_pres));
            end else if (o_pressed != 12'h000) begin
                pressed_bad++;
            end
            if (o_pad_latch && !prev_latch) latch_rises++;
            if (o_pad_latch != (c >= 1 && c <= int'(L))) latch_bad++;
            if (!o_pad_clk && prev_clk) lows++;
            if (o_busy != (c <= int'(VALID_CYC))) busy_bad++;
            prev_latch = o_pad_latch;
            prev_clk   = o_pad_clk;
            if (extra_starts && (c == 10 || c == 128 || c == int'(VALID_CYC))) i_start = 1'b1;
            tick();
        end
        i_start = 1'b0;
        check({tag, "_valid_count"},  32'(valid_cnt),   32'd1);
        check({tag, "_valid_cycle"},  32'(valid_at),    32'(VALID_CYC));
        check({tag, "_latch_pulses"}, 32'(latch_rises), 32'd1);
        check({tag, "_latch_window"}, 32'(latch_bad),   32'd0);
        check({tag, "_low_phases"},   32'(lows),        32'd15);
        check({tag, "_busy_window"},  32'(busy_bad),    32'd0);
        check({tag, "_pressed_idle"}, 32'(pressed_bad), 32'd0);
        check({tag, "_buttons_hold"}, 32'(o_buttons),   32'(exp_btn));
    endtask

    initial begin
        int valid_seen;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        do_poll("up", 16'hFFEF, 12'h010, 12'h010, 1'b1, 1'b0);

        // Abort a poll in cycle 50 (a LOW phase) and confirm nothing completes.
        pad_raw = 16'hFFF7;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 50; c++) tick();
        check("abort_midpoll_clk", 32'(o_pad_clk), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        tick();
        rst_n = 1'b1;
        valid_seen = 0;
        for (int c = 0; c < 140; c++) begin
            if (o_valid) valid_seen++;
            tick();
        end
        check("abort_no_valid", 32'(valid_seen), 32'd0);

        do_poll("fresh",   16'hFFEF, 12'h010, 12'h010, 1'b1, 1'b0);
        do_poll("repeat",  16'hFFEF, 12'h010, 12'h000, 1'b1, 1'b0);
        do_poll("start",   16'hFFF7, 12'h008, 12'h008, 1'b1, 1'b0);
        do_poll("tied0",   16'h0000, 12'h000, 12'h000, 1'b0, 1'b0);
        do_poll("drop",    16'hFFEF, 12'h010, 12'h010, 1'b1, 1'b1);
        do_poll("alt",     16'hF555, 12'hAAA, 12'hAAA, 1'b1, 1'b0);
        do_poll("absent",  16'h0FFF, 12'h000, 12'h000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
